// File: rtl/sdram_pkg.sv
// Shared encodings and defaults for the SDRAM command path (arbiter and timing FSM).
package sdram_pkg;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2,
    CMD_REFRESH = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int REF_INTERVAL_DEF = 780;  // 7.8 us at 100 MHz
  localparam int REF_MAX_DEF      = 7;
  localparam int SRC_W            = 3;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// Requester-side and engine-side signals of the SDRAM command arbiter.
interface sdram_cmd_arbiter_if
  import sdram_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 22,
  parameter int LEN_W   = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic                      cmd_valid;
  logic                      cmd_ready;
  cmd_type_e                 cmd_type;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [LEN_W-1:0]          cmd_len;
  logic [SRC_W-1:0]          cmd_src;
  logic                      cmd_done;

  // Requesters plus the command engine.
  modport master (
    output req, req_we, req_addr, req_len, cmd_ready, cmd_done,
    input  gnt, cmd_valid, cmd_type, cmd_addr, cmd_len, cmd_src
  );

  // The arbiter itself.
  modport slave (
    input  req, req_we, req_addr, req_len, cmd_ready, cmd_done,
    output gnt, cmd_valid, cmd_type, cmd_addr, cmd_len, cmd_src
  );

endinterface

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_req_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] masked;
  logic           found;

  // The upper copy is never masked, so it supplies the wrap-around candidates.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    winner_o = '0;
    found    = 1'b0;
    req_dbl  = {req_i, req_i};
    masked   = req_dbl & ({(2*N){1'b1}} << ptr_i);
    for (int i = 0; i < 2*N; i++) begin
      if (!found && masked[i]) begin
        found    = 1'b1;
        winner_o = IDX_W'(i % N);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Round-robin arbiter in front of the SDRAM command engine with auto-refresh scheduling.
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 22,
  parameter int LEN_W        = 4,
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int REF_MAX      = REF_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sdram_cmd_arbiter_if.slave  bus,
  output logic                busy,
  output logic                ref_overflow
);

  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int CNT_W  = idx_w(REF_INTERVAL);
  localparam int PEND_W = $clog2(REF_MAX + 1);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                cmd_valid_q;
  cmd_type_e           cmd_type_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [LEN_W-1:0]    cmd_len_q;
  logic [SRC_W-1:0]    cmd_src_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]    ref_cnt_q,     ref_cnt_d;
  logic [PEND_W-1:0]   ref_pending_q, ref_pending_d;
  logic                ref_overflow_q, ref_overflow_d;

  logic [IDX_W-1:0]    winner;
  logic                any_req;
  logic [IDX_W-1:0]    rr_next;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                ref_tick;
  logic                ref_take;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i     (bus.req),
    .ptr_i     (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign rr_next    = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
  assign win_onehot = NUM_REQ'(1) << winner;

  assign ref_tick = (ref_cnt_q == '0);
  assign ref_take = cmd_valid_q && bus.cmd_ready && (cmd_type_q == CMD_REFRESH);

  // A tick and a refresh handshake in the same cycle cancel out.
  always_comb begin
    ref_cnt_d      = ref_tick ? CNT_W'(REF_INTERVAL - 1) : ref_cnt_q - CNT_W'(1);
    ref_pending_d  = ref_pending_q;
    ref_overflow_d = ref_overflow_q;
    if (ref_tick && !ref_take) begin
      if (ref_pending_q == PEND_W'(REF_MAX)) ref_overflow_d = 1'b1;
      else                                   ref_pending_d  = ref_pending_q + PEND_W'(1);
    end else if (ref_take && !ref_tick) begin
      ref_pending_d = ref_pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q      <= CNT_W'(REF_INTERVAL - 1);
      ref_pending_q  <= '0;
      ref_overflow_q <= 1'b0;
    end else begin
      ref_cnt_q      <= ref_cnt_d;
      ref_pending_q  <= ref_pending_d;
      ref_overflow_q <= ref_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_NOP;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
      gnt_q <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (ref_pending_q != '0) begin
            // Refresh wins the slot but leaves the round-robin pointer alone.
            cmd_type_q  <= CMD_REFRESH;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_src_q   <= '0;
            cmd_valid_q <= 1'b1;
            state_q     <= ARB_ISSUE;
          end else if (any_req) begin
            gnt_q       <= win_onehot;
            cmd_type_q  <= bus.req_we[winner] ? CMD_WRITE : CMD_READ;
            cmd_addr_q  <= bus.req_addr[winner*ADDR_W +: ADDR_W];
            cmd_len_q   <= bus.req_len[winner*LEN_W +: LEN_W];
            cmd_src_q   <= SRC_W'(winner);
            rr_ptr_q    <= rr_next;
            cmd_valid_q <= 1'b1;
            state_q     <= ARB_ISSUE;
          end else begin
            cmd_type_q <= CMD_NOP;
          end
        end
        ARB_ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.cmd_done) begin
            cmd_type_q <= CMD_NOP;
            state_q    <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.cmd_src   = cmd_src_q;
  assign busy          = (state_q != ARB_IDLE);
  assign ref_overflow  = ref_overflow_q;

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
Single-clock arbiter and scheduler in front of the SDRAM command engine. It shares the engine between NUM_REQ requesters (write-FIFO drain, read-request ports, host). Requesters are served round-robin. The block also generates periodic auto-refresh requests, which pre-empt normal arbitration at the next idle slot. It sits between the FIFO-side request logic and the SDRAM command/timing FSM, and carries one transaction at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 22, SDRAM word address width (bank+row+col)
LEN_W, 4, burst length field width; len 0 means 1 beat
REF_INTERVAL, 780, clk cycles between refresh ticks (7.8 us at 100 MHz)
REF_MAX, 7, saturation limit of pending-refresh counter

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester request; held until its gnt bit pulses
req_we  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*LEN_W  flattened burst lengths
gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
cmd_valid  out  1  command to engine valid
cmd_ready  in  1  engine accepts command
cmd_type  out  2  0=NOP, 1=READ, 2=WRITE, 3=REFRESH
cmd_addr  out  ADDR_W  latched address (0 for REFRESH)
cmd_len  out  LEN_W  latched length (0 for REFRESH)
cmd_src  out  3  index of granted requester (0 for REFRESH)
cmd_done  in  1  engine pulse: current transaction complete
busy  out  1  FSM not in IDLE
ref_overflow  out  1  sticky: refresh tick arrived while pending==REF_MAX

Behaviour:
- Synchronous active-high reset. On rst=1 at a posedge:
  - state=IDLE.
  - gnt, cmd_valid, cmd_type, cmd_addr, cmd_len, cmd_src, busy, ref_overflow all 0.
  - rr_ptr=0, ref_pending=0, ref_cnt=REF_INTERVAL-1.
- Reset mid-transaction aborts without handshake. The engine shares rst.
- FSM has three states: IDLE, ISSUE, WAIT.
  - IDLE, ref_pending>0: latch cmd_type=REFRESH, addr/len/src=0, go to ISSUE. No gnt pulse.
  - IDLE, ref_pending==0 and any req: pick the winner by round-robin from rr_ptr. The winner is the first set bit at index >= rr_ptr, wrapping modulo NUM_REQ. Latch type (WRITE if req_we else READ), addr, len, src. Go to ISSUE. Set rr_ptr=(winner+1) mod NUM_REQ.
  - IDLE, nothing pending: stay; cmd_type=NOP.
  - ISSUE: cmd_valid=1 with stable fields until cmd_valid&&cmd_ready, then go to WAIT. cmd_valid drops the cycle after the handshake.
  - WAIT: on cmd_done go to IDLE. cmd_done in any other state is ignored.
- Latency:
  - req sampled in IDLE at cycle N gives cmd_valid=1 and gnt[winner]=1 at cycle N+1.
  - gnt is a single pulse in the first ISSUE cycle only.
  - The requester drops or advances req after gnt.
  - Minimum back-to-back spacing is 3 cycles: ISSUE, WAIT with cmd_done same cycle as entry+1, then IDLE.
- Refresh timer:
  - ref_cnt decrements every cycle. At 0 it reloads REF_INTERVAL-1 and produces a tick.
  - A tick increments ref_pending. At REF_MAX the counter saturates and ref_overflow is set instead; ref_overflow clears only on reset.
  - A REFRESH handshake (cmd_valid&&cmd_ready with type REFRESH) decrements ref_pending.
  - Tick and decrement in the same cycle: ref_pending unchanged.
- Refresh never pre-empts a transaction already in ISSUE or WAIT. It waits for IDLE.
- Round-robin does not advance on REFRESH commands.
- req changes while in ISSUE or WAIT are ignored. The latched command fields never change outside IDLE.
- cmd_src is zero-extended. NUM_REQ <= 8.

Decomposition:
- Shared package sdram_pkg holds:
  - cmd_type encodings CMD_NOP, CMD_READ, CMD_WRITE, CMD_REFRESH.
  - FSM state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT.
  - The default REF_INTERVAL constant, reused by the timing FSM.
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_req.
  - Implemented as a double-width mask-and-priority-encode. Reusable by the read-data return mux.

Test Plan:
- Reset then idle 20 cycles: gnt=0, cmd_valid=0, cmd_type=NOP, busy=0 throughout; set rst=1 while in WAIT and confirm all outputs return to 0 the next cycle.
- req=4'b0100, req_we[2]=1, addr=0x01234, len=3, cmd_ready=1 constantly: next cycle gnt=4'b0100, cmd_valid=1, cmd_type=WRITE, cmd_addr=0x01234, cmd_len=3, cmd_src=2.
- req=4'b1111 held, cmd_ready=1, cmd_done one cycle after each handshake: grants in order 0,1,2,3,0,1; never the same requester twice in a row.
- cmd_ready=0 for 5 cycles in ISSUE with req changing meanwhile: cmd_valid stays 1, fields unchanged, gnt pulses exactly once.
- REF_INTERVAL=16, req=4'b0001 held: after the first tick the next IDLE issues REFRESH with addr=0, src=0, and no gnt; rr_ptr is unaffected and requester 0 is granted right after.
- REF_INTERVAL=4, cmd_ready=0 throughout: ref_pending reaches 7 and the following tick sets ref_overflow=1, which stays 1 until rst.
